// File: rtl/fir_pipeline_param_if.sv
// fir_pipeline_param_if: sample stream, coefficient load port
// and filtered output bundle for fir_pipeline_param.
interface fir_pipeline_param_if #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 16
);
  localparam int AW = $clog2(TAPS);

  logic                     in_valid;
  logic signed [DATA_W-1:0] data_in;
  logic                     coef_we;
  logic [AW-1:0]            coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic                     coef_commit;
  logic                     out_valid;
  logic signed [DATA_W-1:0] data_out;

  modport master (
    output in_valid,
    output data_in,
    output coef_we,
    output coef_addr,
    output coef_data,
    output coef_commit,
    input  out_valid,
    input  data_out
  );

  modport slave (
    input  in_valid,
    input  data_in,
    input  coef_we,
    input  coef_addr,
    input  coef_data,
    input  coef_commit,
    output out_valid,
    output data_out
  );
endinterface

// File: rtl/fir_pipeline_param.sv
// fir_pipeline_param: pipelined direct-form FIR, gappable input,
// double-buffered coefficients. FIR_SAT_EN selects saturating output.
module fir_pipeline_param #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int TAPS      = 16,
  parameter int FRAC_BITS = 14
) (
  input logic                clk,
  input logic                reset,
  fir_pipeline_param_if.slave bus
);
  localparam int L     = $clog2(TAPS);
  localparam int P2    = 1 << L;
  localparam int AW    = $clog2(TAPS);
  localparam int MUL_W = DATA_W + COEF_W;
  localparam int ACC_W = MUL_W + L;
  localparam int NODES = 2 * P2;

  localparam logic signed [COEF_W-1:0] ONE =
    {{(COEF_W-1){1'b0}}, 1'b1} << FRAC_BITS;
  localparam logic signed [ACC_W-1:0] RND =
    ({{(ACC_W-1){1'b0}}, 1'b1} << FRAC_BITS) >> 1;

  logic signed [DATA_W-1:0] x         [TAPS];
  logic signed [COEF_W-1:0] shadow    [TAPS];
  logic signed [COEF_W-1:0] shadow_nx [TAPS];
  logic signed [COEF_W-1:0] active    [TAPS];
  logic signed [ACC_W-1:0]  prod      [P2];
  // Heap-ordered tree: node[1] is the root, leaves are node[P2..].
  logic signed [ACC_W-1:0]  node      [1:NODES-1];
  logic [L+1:0]             vpipe;
  logic signed [ACC_W-1:0]  sum_rnd;
  logic signed [DATA_W-1:0] res;
  logic                     unused_bits;

  // Shadow bank with this cycle's write folded in, so a
  // same-cycle commit picks it up.
  always_comb begin
    for (int i = 0; i < TAPS; i++) begin
      shadow_nx[i] = shadow[i];
      if (bus.coef_we && bus.coef_addr == AW'(i))
        shadow_nx[i] = bus.coef_data;
    end
  end

  // Coefficient banks: shadow takes writes, active takes commits.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) begin
        shadow[i] <= (i == 0) ? ONE : '0;
        active[i] <= (i == 0) ? ONE : '0;
      end
    end else begin
      for (int i = 0; i < TAPS; i++) begin
        shadow[i] <= shadow_nx[i];
        if (bus.coef_commit)
          active[i] <= shadow_nx[i];
      end
    end
  end

  // Delay line advances only on accepted samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++)
        x[i] <= '0;
    end else if (bus.in_valid) begin
      x[0] <= bus.data_in;
      for (int i = 1; i < TAPS; i++)
        x[i] <= x[i-1];
    end
  end

  // Full-precision products, sign-extended; pad leaves are zero.
  always_comb begin
    for (int j = 0; j < P2; j++)
      prod[j] = '0;
    for (int j = 0; j < TAPS; j++)
      prod[j] = ACC_W'(MUL_W'(x[j]) * MUL_W'(active[j]));
  end

  // Product registers plus one registered adder level per tree depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 1; n < NODES; n++)
        node[n] <= '0;
    end else begin
      for (int j = 0; j < P2; j++)
        node[P2+j] <= prod[j];
      for (int n = 1; n < P2; n++)
        node[n] <= node[2*n] + node[2*n+1];
    end
  end

  // Valid tag travels beside the data: x, P, L tree levels.
  always_ff @(posedge clk) begin
    if (reset)
      vpipe <= '0;
    else
      vpipe <= {vpipe[L:0], bus.in_valid};
  end

  assign sum_rnd = node[1] + RND;

`ifdef FIR_SAT_EN
  localparam logic signed [ACC_W-1:0] MAXV =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [ACC_W-1:0] shr;

  assign shr = sum_rnd >>> FRAC_BITS;
  assign unused_bits = ^sum_rnd[FRAC_BITS-1:0];

  // Clamp the rounded sum into the output range.
  always_comb begin
    res = shr[DATA_W-1:0];
    if (shr > MAXV)
      res = MAXV[DATA_W-1:0];
    else if (shr < MINV)
      res = MINV[DATA_W-1:0];
  end
`else
  // Wrap: the low DATA_W bits of the shifted sum.
  assign res = sum_rnd[FRAC_BITS +: DATA_W];
  assign unused_bits = ^{sum_rnd[ACC_W-1:FRAC_BITS+DATA_W],
                         sum_rnd[FRAC_BITS-1:0]};
`endif

  // Output register: data updates every edge, valid from the tag pipe.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.data_out  <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.data_out  <= res;
      bus.out_valid <= vpipe[L+1];
    end
  end
endmodule

// File: doc/fir_pipeline_param.md
# fir_pipeline_param

- Parametrised, pipelined direct-form FIR filter for the audio denoising path.
- Generalises tap count, sample width and coefficient width.
- Adds a valid-qualified (gappable) sample stream, runtime-loadable double-buffered coefficients, and a fixed-point round/saturate output stage.
- Sits between the sample source (file-driven bench or audio front end) and the output writer; one output sample per accepted input sample.

## Interface
- DATA_W, 16: signed sample width (in and out)
- COEF_W, 16: signed coefficient width
- TAPS, 16: number of taps, ≥2 (any value; the adder tree zero-pads to a power of two)
- FRAC_BITS, 14: coefficient fraction bits, ≤ COEF_W-2
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  data_in is a new sample this cycle
- data_in  in  DATA_W  signed input sample
- coef_we  in  1  write coef_data into shadow bank at coef_addr
- coef_addr  in  clog2(TAPS)  tap index; values ≥ TAPS are ignored
- coef_data  in  COEF_W  signed coefficient
- coef_commit  in  1  copy shadow bank to active bank
- out_valid  out  1  data_out holds a new result
- data_out  out  DATA_W  signed filtered sample

## Operation
**Delay line x[0..TAPS-1]**
- Shifts only on edges where in_valid=1: x[0]←data_in, x[i]←x[i-1].
- Holds otherwise.

**Stage P (product)**
- Every edge: p[i] ← x[i]*active[i] (full DATA_W+COEF_W signed).

**Tree stages T1..TL**
- L = clog2(TAPS) registered pairwise-add levels.
- Accumulator width ACC_W = DATA_W+COEF_W+L; sign-extended; no overflow possible.

**Output stage O**
- r = (sum + 2^(FRAC_BITS-1)) >>> FRAC_BITS (arithmetic shift; round half toward +inf).
- data_out ← r, narrowed per Configuration.

**Valid tag**
- A 1-bit shift pipe carries in_valid alongside the data stages to out_valid.
- data_out updates every edge; it is meaningful only when out_valid=1.

**Coefficients**
- coef_we writes the shadow bank.
- coef_commit copies all shadow taps to the active bank at the edge.
- coef_we and coef_commit in the same cycle: the commit includes the same-cycle write.
- Writes without a commit never affect output.

**Reset**
- Applies to the delay line, all pipeline registers, valid pipe, data_out=0 and out_valid=0.
- Both coefficient banks reset to identity: tap0 = 2^FRAC_BITS, others 0.

## Timing
- Latency LAT = L+2 edges from the edge that captures data_in (in_valid=1) to the edge that asserts out_valid for it. TAPS=16 gives LAT=6.
- Throughput: one sample per clock. Arbitrary gaps are allowed. The out_valid pattern equals the in_valid pattern delayed by LAT.
- Results depend only on the sequence of valid samples, not on gap spacing.
- Commit at edge k: a sample captured at edge k or later uses the new active bank.
- Samples captured before edge k whose products are not yet formed would mix coefficient sets. Therefore commit only with no in_valid for the preceding cycle, or accept a one-sample mixed result; this is not flagged.
- Reset asserted mid-stream:
  - out_valid=0 and data_out=0 from the next edge.
  - All in-flight samples are dropped.
  - The first post-reset output appears LAT edges after the first accepted sample.
- The delay line starts at zero after reset, so the first TAPS-1 outputs see zero history.

## Configuration
- FIR_SAT_EN defined: r is clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- FIR_SAT_EN undefined: data_out = r[DATA_W-1:0] (two's-complement wrap). Saves the comparators.

## Test plan
- **Identity after reset:** reset 2 cycles; in_valid=1 with data_in=0x1234 for one cycle, then 0 → out_valid=1 exactly 6 edges later, data_out=0x1234; a single pulse.
- **Impulse response:**
  - Stimulus: write c[i]=100*i for i=0..15; commit; idle one cycle; feed 0x4000 then 16 zeros, all in_valid=1.
  - Response: consecutive outputs 0,100,200,…,1500, then 0.
- **Overflow:**
  - Stimulus: all c[i]=0x3FFF; commit; feed 0x7FFF for 16 valid cycles.
  - Response: 16th output is 0x7FFF with FIR_SAT_EN, 0xFFD0 without (r=524240).
- **Gapped stream:**
  - Stimulus: same sample sequence as the impulse test, with in_valid toggling 1,0,0,1,…
  - Response: identical output values; out_valid pattern equals in_valid delayed 6.
- **Shadow isolation:**
  - Stimulus: with identity active, write c[0]=0x2000 without commit, then feed 0x0100.
  - Response: output 0x0100.
  - Then commit and feed 0x0100 → 0x0080.
- **Reset mid-stream:**
  - Stimulus: assert reset while 3 samples are in flight.
  - Response: no out_valid for those samples; coefficients back to identity; the next sample passes unchanged after 6 edges.
